vga_timing_gen: RTL and testbench

- Pixel timing generator for the 640x480@60 VGA path, running on the 25 MHz pixel clock.
- Produces the 10-bit HorizontalCounter/VerticalCounter pair consumed directly by coord_gen.
- Also produces hsync, vsync, display_enable and frame/line strobes for the downstream character and pixel stages.
- All outputs are registered and mutually consistent in every cycle.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_axis_gen.sv | 59 +++++
 rtl/vga_timing_gen.sv | 65 ++++++
 tb/tb_vga_timing_gen.sv | 127 ++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, counter width and axis phase type
package vga_pkg;
    localparam int CNT_W       = 10;
    localparam int H_VISIBLE_D = 640;
    localparam int H_FRONT_D   = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BACK_D    = 48;
    localparam int V_VISIBLE_D = 480;
    localparam int V_FRONT_D   = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BACK_D    = 33;
    localparam int H_TOTAL_D   = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
    localparam int V_TOTAL_D   = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phaseT;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: timing outputs shared by the generator and the character/pixel stages
// (blink exists only with VGA_BLINK_EN)
interface vga_timing_gen_if;
    import vga_pkg::*;
    logic [CNT_W-1:0] HorizontalCounter;
    logic [CNT_W-1:0] VerticalCounter;
    phaseT hPhase;
    phaseT vPhase;
    logic hsync;
    logic vsync;
    logic display_enable;
    logic line_start;
    logic frame_start;
`ifdef VGA_BLINK_EN
    logic blink;
    modport master(output HorizontalCounter, VerticalCounter, hPhase, vPhase, hsync, vsync,
                   display_enable, line_start, frame_start, blink);
    modport slave(input HorizontalCounter, VerticalCounter, hPhase, vPhase, hsync, vsync,
                  display_enable, line_start, frame_start, blink);
`else
    modport master(output HorizontalCounter, VerticalCounter, hPhase, vPhase, hsync, vsync,
                   display_enable, line_start, frame_start);
    modport slave(input HorizontalCounter, VerticalCounter, hPhase, vPhase, hsync, vsync,
                  display_enable, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_axis_gen.sv
// vga_axis_gen: one timing axis -- wrapping counter, phase FSM and registered sync decode
module vga_axis_gen
    import vga_pkg::*;
#(
    parameter int VISIBLE_LEN     = H_VISIBLE_D,
    parameter int FRONT_LEN       = H_FRONT_D,
    parameter int SYNC_LEN        = H_SYNC_D,
    parameter int BACK_LEN        = H_BACK_D,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clock25,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output phaseT            phase,
    output logic             wrap,
    output logic             sync,
    output logic             visible
);
    localparam int TOTAL = VISIBLE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(VISIBLE_LEN);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(VISIBLE_LEN + FRONT_LEN);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(VISIBLE_LEN + FRONT_LEN + SYNC_LEN);
    localparam logic [1:0] ST_ACTIVE = 2'(ACTIVE);
    localparam logic [1:0] ST_FRONT  = 2'(FRONT);
    localparam logic [1:0] ST_SYNC   = 2'(SYNC);
    localparam logic [1:0] ST_BACK   = 2'(BACK);

    if (TOTAL > (1 << CNT_W)) begin : totalTooLarge
        $error("vga_axis_gen: axis total %0d does not fit a %0d-bit counter", TOTAL, CNT_W);
    end

    logic [CNT_W-1:0] countNext;
    logic [1:0] state, stateNext;

    // >= rather than == so a corrupted out-of-range count wraps on its next advance
    assign wrap      = advance && (count >= LAST);
    assign countNext = wrap ? '0 : count + CNT_W'(advance);
    assign stateNext = countNext == '0      ? ST_ACTIVE :
                       countNext == FRONT_AT ? ST_FRONT  :
                       countNext == SYNC_AT  ? ST_SYNC   :
                       countNext == BACK_AT  ? ST_BACK   : state;
    // next-state decode: the top registers it alongside the counters
    assign visible   = stateNext == ST_ACTIVE;
    assign phase     = phaseT'(state);

    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            count <= '0;
            state <= ST_ACTIVE;
            sync  <= SYNC_ACTIVE_LOW;
        end else begin
            count <= countNext;
            state <= stateNext;
            sync  <= (stateNext == ST_SYNC) ^ SYNC_ACTIVE_LOW;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel timing generator with zero-skew registered outputs
// (VGA_BLINK_EN adds a 32-frame blink output)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE       = H_VISIBLE_D,
    parameter int H_FRONT         = H_FRONT_D,
    parameter int H_SYNC          = H_SYNC_D,
    parameter int H_BACK          = H_BACK_D,
    parameter int V_VISIBLE       = V_VISIBLE_D,
    parameter int V_FRONT         = V_FRONT_D,
    parameter int V_SYNC          = V_SYNC_D,
    parameter int V_BACK          = V_BACK_D,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input logic              clock25,
    input logic              reset,
    vga_timing_gen_if.master vga
);
    logic hWrap, vWrap, hVisible, vVisible;

    vga_axis_gen #(
        .VISIBLE_LEN(H_VISIBLE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK),
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) hAxis (
        .clock25(clock25), .reset(reset), .advance(1'b1),
        .count(vga.HorizontalCounter), .phase(vga.hPhase), .wrap(hWrap),
        .sync(vga.hsync), .visible(hVisible)
    );

    vga_axis_gen #(
        .VISIBLE_LEN(V_VISIBLE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK),
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) vAxis (
        .clock25(clock25), .reset(reset), .advance(hWrap),
        .count(vga.VerticalCounter), .phase(vga.vPhase), .wrap(vWrap),
        .sync(vga.vsync), .visible(vVisible)
    );

    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            vga.display_enable <= 1'b0;
            vga.line_start     <= 1'b0;
            vga.frame_start    <= 1'b0;
        end else begin
            vga.display_enable <= hVisible && vVisible;
            vga.line_start     <= hWrap;
            vga.frame_start    <= hWrap && vWrap;
        end
    end

`ifdef VGA_BLINK_EN
    logic [4:0] frameCount;

    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            frameCount <= '0;
            vga.blink  <= 1'b0;
        end else if (hWrap && vWrap) begin
            frameCount <= frameCount + 5'd1;
            vga.blink  <= (&frameCount) ? ~vga.blink : vga.blink;
        end
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default-timing instance and a reduced-timing,
// inverted-polarity instance that reaches frame wraps within a short run
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    vga_timing_gen_if bus();
    vga_timing_gen_if busS();

    vga_timing_gen dut (.clock25(clk), .reset(rst), .vga(bus));

    // 15 pixels x 10 lines: H sync 10..12, V sync 7..8, active-high sync
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1'b0)
    ) dutS (.clock25(clk), .reset(rst), .vga(busS));

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int hsyncLow = 0;
    int deHigh = 0;
    int fsSeen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, " H"}, bus.HorizontalCounter, 0);
        check({tag, " V"}, bus.VerticalCounter, 0);
        check({tag, " hsync"}, bus.hsync, 1);
        check({tag, " vsync"}, bus.vsync, 1);
        check({tag, " de"}, bus.display_enable, 0);
        check({tag, " line_start"}, bus.line_start, 0);
        check({tag, " frame_start"}, bus.frame_start, 0);
        check({tag, " hPhase"}, bus.hPhase, 0);
        check({tag, " small H"}, busS.HorizontalCounter, 0);
        check({tag, " small V"}, busS.VerticalCounter, 0);
        check({tag, " small hsync"}, busS.hsync, 0);
        check({tag, " small vsync"}, busS.vsync, 0);
        check({tag, " small de"}, busS.display_enable, 0);
`ifdef VGA_BLINK_EN
        check({tag, " blink"}, busS.blink, 0);
`endif
    endtask

    // k = rising edges since reset release
    task automatic checkAt(input int k);
        int h, v, hs, vs;
        h = k % 800;
        v = (k / 800) % 525;
        hs = k % 15;
        vs = (k / 15) % 10;
        cyc = k;
        check("H", bus.HorizontalCounter, h);
        check("V", bus.VerticalCounter, v);
        check("hsync", bus.hsync, !(h >= 656 && h <= 751));
        check("vsync", bus.vsync, !(v >= 490 && v <= 491));
        check("de", bus.display_enable, h < 640 && v < 480);
        check("line_start", bus.line_start, h == 0);
        check("frame_start", bus.frame_start, h == 0 && v == 0);
        check("hPhase", bus.hPhase, h < 640 ? 0 : h < 656 ? 1 : h < 752 ? 2 : 3);
        check("vPhase", bus.vPhase, v < 480 ? 0 : v < 490 ? 1 : v < 492 ? 2 : 3);
        check("small H", busS.HorizontalCounter, hs);
        check("small V", busS.VerticalCounter, vs);
        check("small hsync", busS.hsync, hs >= 10 && hs <= 12);
        check("small vsync", busS.vsync, vs >= 7 && vs <= 8);
        check("small de", busS.display_enable, hs < 8 && vs < 6);
        check("small line_start", busS.line_start, hs == 0);
        check("small frame_start", busS.frame_start, hs == 0 && vs == 0);
        check("small vPhase", busS.vPhase, vs < 6 ? 0 : vs < 7 ? 1 : vs < 9 ? 2 : 3);
        if (busS.frame_start === 1'b1) fsSeen++;
`ifdef VGA_BLINK_EN
        check("blink", busS.blink, fsSeen >= 32 && fsSeen < 64);
`endif
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        for (int k = 1; k <= 1700; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkAt(k);
            if (k >= 800 && k < 1600) begin
                hsyncLow += (bus.hsync === 1'b0) ? 1 : 0;
                deHigh += (bus.display_enable === 1'b1) ? 1 : 0;
            end
        end
        check("hsync low cycles per line", hsyncLow, 96);
        check("de high cycles per line", deHigh, 640);

        #5 rst = 1'b1;
        #1 checkReset("async reset");
        @(negedge clk);
        checkReset("held reset");
        rst = 1'b0;
        fsSeen = 0;
`ifdef VGA_BLINK_EN
        for (int k = 1; k <= 9601; k++) begin
`else
        for (int k = 1; k <= 200; k++) begin
`endif
            @(posedge clk);
            @(negedge clk);
            checkAt(k);
        end
`ifdef VGA_BLINK_EN
        check("frame_start count over 64 frames", fsSeen, 64);
`else
        check("frame_start count after restart", fsSeen, 1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
